// File: rtl/dm_access_unit.sv
// dm_access_unit: M-stage load/store initiator for a word-wide data memory.
// Sub-word stores are read-modify-write; misaligned or out-of-range
// requests are rejected at acceptance and never reach the memory.
//
// Handshake: a request is taken on a rising clk edge when req_valid and
// req_ready are both high. req_ready is high only in IDLE, so the request
// fields are sampled once and ignored until the unit is idle again.
// rsp_valid is a single-cycle completion pulse, with rsp_err and rsp_rdata
// meaningful in that cycle.
module dm_access_unit #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;   // store data, later overwritten by the merged word
  logic [31:0] r_pc;
  logic        r_err;
  logic [31:0] rdata_q;

  logic        accept;
  logic        req_err;
  logic        mem_active;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign accept = req_valid && (state_q == IDLE);

  // Reject illegal size, misalignment and addresses past the memory.
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11)                           req_err = 1'b1;
    if ((req_size == 2'b01) && req_addr[0])          req_err = 1'b1;
    if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
    if (req_addr >= ADDR_LIMIT)                      req_err = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err)                state_d = RESP;
          else if (!req_we)           state_d = LOAD;
          else if (req_size == 2'b10) state_d = WRITE;
          else                        state_d = RMW_RD;
        end
      end
      LOAD:    state_d = RESP;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane extraction and extension of the loaded word (little-endian lanes).
  always_comb begin
    byte_sel  = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    half_sel  = mem_rdata[{r_addr[1], 4'b0000} +: 16];
    load_data = mem_rdata;
    case (r_size)
      2'b00:   load_data = r_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_data = r_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  // Merge the right-aligned store data into the word read back.
  always_comb begin
    merged = mem_rdata;
    if (r_size == 2'b00)      merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    else if (r_size == 2'b01) merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
  end

  // Request capture, merge buffer and response data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_pc       <= 32'h0;
      r_err      <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      if (accept) begin
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_pc       <= req_pc;
        r_err      <= req_err;
        if (req_err) rdata_q <= 32'h0;
      end
      if (state_q == LOAD)   rdata_q <= load_data;
      if (state_q == RMW_RD) r_wdata <= merged;
      if (state_q == WRITE)  rdata_q <= 32'h0;
    end
  end

  assign mem_active = (state_q == LOAD) || (state_q == RMW_RD) || (state_q == WRITE);

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = (state_q == RESP) && r_err;
  assign rsp_rdata = rdata_q;
  assign mem_we    = (state_q == WRITE);
  assign mem_wdata = (state_q == WRITE) ? r_wdata : 32'h0;
  assign mem_addr  = mem_active ? {r_addr[31:2], 2'b00} : 32'h0;
  assign mem_pc    = mem_active ? r_pc : 32'h0;
  assign dbg_state = state_q;

endmodule

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
- Load/store initiator for the M stage. Drives the word-wide data memory port: word address, write data, write enable and PC. Reads the memory's combinational read data back.
- Supports byte, halfword and word loads with sign or zero extension. Sub-word stores are done as read-modify-write.
- Misaligned and out-of-range accesses are rejected and flagged; they never reach the memory.
- Uses a valid/ready handshake towards the pipeline, which stalls while req_ready is low.

Parameters:
- ADDR_LIMIT, 32'h0000_3000: first illegal byte address (3072 words); any req_addr >= ADDR_LIMIT is an error.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned for sub-word sizes
- req_pc  input  32  PC of the issuing instruction
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  with rsp_valid: access rejected
- mem_addr  output  32  word-aligned address {a[31:2],2'b00}
- mem_wdata  output  32  full-word write data
- mem_we  output  1  memory write enable
- mem_pc  output  32  PC forwarded to the memory trace
- mem_rdata  input  32  combinational read of the word at mem_addr

Behaviour:
- Little-endian byte lanes: byte k of a word = bits [8k+7:8k].
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- req_ready = 1 only in IDLE.
- Handshake: a request is accepted on a rising edge with req_valid & req_ready. All req_* inputs are registered; inputs are ignored in the other states.
- Error check at acceptance:
  - size 11;
  - half with a[0] = 1;
  - word with a[1:0] != 0;
  - a >= ADDR_LIMIT.
  - An error goes IDLE->RESP with rsp_err = 1, rsp_rdata = 0; mem_we never asserts.
- Load: IDLE->LOAD->RESP.
  - In LOAD, mem_addr drives the aligned word.
  - At the LOAD->RESP edge the lane is selected from mem_rdata, extended and registered into rsp_rdata.
- Word store: IDLE->WRITE->RESP.
  - In WRITE: mem_we = 1, mem_wdata = registered wdata.
- Sub-word store: IDLE->RMW_RD->WRITE->RESP.
  - At the RMW_RD->WRITE edge, mem_rdata is captured into a merge buffer with the target lane(s) replaced by wdata[7:0] or wdata[15:0].
  - WRITE writes the merged word.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE. rsp_err is 0 on good accesses.
- Latency from accept edge to rsp_valid:
  - 1 cycle: error;
  - 2 cycles: load, word store;
  - 3 cycles: sub-word store.
  - Next acceptance is possible in the cycle after RESP.
- mem_we is decoded from state only: high only in WRITE, exactly one cycle per store.
- mem_addr, mem_pc are the registered values in LOAD/RMW_RD/WRITE; 0 in IDLE/RESP.
- mem_wdata is 0 outside WRITE.
- rsp_rdata holds until the next RESP load/error/store update; a store response sets it to 0.
- Reset (reset = 0, asynchronous):
  - state = IDLE; all registers 0.
  - req_ready = 1 once reset is released; rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_pc = 0.
- Reset mid-operation: the operation is aborted with no response. If reset hits in RMW_RD, no write occurs. If it hits in WRITE, mem_we drops immediately and the write is not committed.
- req_valid held high in RESP is not accepted until IDLE; no request is lost or duplicated.

Test Plan:
- Word store then load: sw 0x12345678 @0x10 -> mem_we one cycle with mem_addr 0x10, wdata 0x12345678, mem_pc = req_pc; lw @0x10 -> rsp_rdata 0x12345678, 2 cycles after accept.
- Byte RMW: memory word @0x20 = 0xAABBCCDD; sb 0x11 @0x22 -> write 0xAA11CCDD; lb @0x23 -> 0xFFFFFFAA; lbu @0x23 -> 0x000000AA.
- Halfword: sh 0x8001 @0x26 over 0 -> write 0x80010000; lh @0x26 -> 0xFFFF8001; lhu -> 0x00008001.
- Errors: lw @0x12, lh @0x13, size 11, sw @0x3000 -> rsp_valid with rsp_err = 1 one cycle after accept, rsp_rdata 0, mem_we never 1.
- Back-to-back: req_valid held high with 3 queued requests -> each accepted only while req_ready = 1, exactly 3 rsp_valid pulses, in order.
- Reset mid-operation: drop reset during RMW_RD of sb -> no mem_we, state IDLE, rsp_valid 0, req_ready 1 after release; memory word unchanged.
